// File: rtl/flag_pkg.sv
// Shared types and constants for the Nordic-cross flag painter.
// Colours are packed {r,g,b}; CFG_SWEDEN is the configuration loaded at reset.
package flag_pkg;

    localparam int CORDW = 10;
    localparam int COLRW = 4;

    typedef struct packed {
        logic [COLRW-1:0] r;
        logic [COLRW-1:0] g;
        logic [COLRW-1:0] b;
    } colour_t;

    // cross colour is called crs: "cross" is a reserved word
    typedef struct packed {
        logic [CORDW-1:0] cx;
        logic [CORDW-1:0] cw;
        logic [CORDW-1:0] cy;
        logic [CORDW-1:0] ch;
        logic [CORDW-1:0] inset;
        colour_t          bg;
        colour_t          crs;
        colour_t          inner;
    } cross_cfg_t;

    typedef struct packed {
        colour_t bg;
        colour_t crs;
        colour_t inner;
    } palette_t;

    localparam cross_cfg_t CFG_SWEDEN = '{
        cx:    CORDW'(200),
        cw:    CORDW'(80),
        cy:    CORDW'(160),
        ch:    CORDW'(80),
        inset: '0,
        bg:    '{r: COLRW'(4'h0), g: COLRW'(4'h6), b: COLRW'(4'hA)},
        crs:   '{r: COLRW'(4'hF), g: COLRW'(4'hC), b: COLRW'(4'h0)},
        inner: '{r: COLRW'(4'hF), g: COLRW'(4'hC), b: COLRW'(4'h0)}
    };

endpackage

// File: rtl/flag_band_cmp.sv
// Half-open band test along one axis, plus the inset inner band.
// All edges use W+1 bits so start+width never wraps back onto low coordinates.
module flag_band_cmp #(
    parameter int W = 10
) (
    input  logic [W-1:0] coord_i,
    input  logic [W-1:0] start_i,
    input  logic [W-1:0] width_i,
    input  logic [W-1:0] inset_i,
    output logic         in_band_o,
    output logic         in_inner_o
);

    logic [W:0] c, lo, hi, ilo, ihi, dbl;
    logic       inner_en;

    always_comb begin
        c        = {1'b0, coord_i};
        lo       = {1'b0, start_i};
        hi       = lo + {1'b0, width_i};
        dbl      = {inset_i, 1'b0};
        // hi - inset cannot underflow once 2*inset < width is known
        inner_en = (inset_i != '0) && (dbl < {1'b0, width_i});
        ilo      = lo + {1'b0, inset_i};
        ihi      = hi - {1'b0, inset_i};
        in_band_o  = (c >= lo) && (c < hi);
        in_inner_o = inner_en && (c >= ilo) && (c < ihi);
    end

endmodule

// File: rtl/flag_nordic_cross.sv
// Two-stage Nordic-cross flag painter with a handshaked shadow configuration
// that is promoted to the active configuration only on a frame pulse.
module flag_nordic_cross #(
    parameter int CORDW  = flag_pkg::CORDW,
    parameter int COLRW  = flag_pkg::COLRW,
    parameter int FLAG_W = 640,
    parameter int FLAG_H = 400
) (
    input  logic               clk_pix,
    input  logic               rst_pix_n,
    input  logic               frame,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CORDW-1:0]   cfg_cx,
    input  logic [CORDW-1:0]   cfg_cw,
    input  logic [CORDW-1:0]   cfg_cy,
    input  logic [CORDW-1:0]   cfg_ch,
    input  logic [CORDW-1:0]   cfg_inset,
    input  logic [3*COLRW-1:0] cfg_bg,
    input  logic [3*COLRW-1:0] cfg_cross,
    input  logic [3*COLRW-1:0] cfg_inner,
    input  logic               de,
    input  logic [CORDW-1:0]   sx,
    input  logic [CORDW-1:0]   sy,
    output logic               paint_de,
    output logic [COLRW-1:0]   paint_r,
    output logic [COLRW-1:0]   paint_g,
    output logic [COLRW-1:0]   paint_b
);

    import flag_pkg::*;

    localparam logic [CORDW:0] FW = (CORDW+1)'(FLAG_W);
    localparam logic [CORDW:0] FH = (CORDW+1)'(FLAG_H);

    logic       pend_q, pend_d;
    cross_cfg_t shadow_q, shadow_d;
    cross_cfg_t active_q, active_d;
    cross_cfg_t cfg_in;
    logic       xfer;

    logic       s1_de_q, s1_de_d;
    logic       s1_out_q, s1_out_d;
    logic       s1_band_q, s1_band_d;
    logic       s1_inner_q, s1_inner_d;
    palette_t   s1_pal_q, s1_pal_d;

    logic       paint_de_q, paint_de_d;
    colour_t    paint_q, paint_d;

    logic       vbar, hbar, vinner, hinner;

    flag_band_cmp #(.W(CORDW)) u_cmp_x (
        .coord_i    (sx),
        .start_i    (active_q.cx),
        .width_i    (active_q.cw),
        .inset_i    (active_q.inset),
        .in_band_o  (vbar),
        .in_inner_o (vinner)
    );

    flag_band_cmp #(.W(CORDW)) u_cmp_y (
        .coord_i    (sy),
        .start_i    (active_q.cy),
        .width_i    (active_q.ch),
        .inset_i    (active_q.inset),
        .in_band_o  (hbar),
        .in_inner_o (hinner)
    );

    always_comb begin
        cfg_in.cx    = cfg_cx;
        cfg_in.cw    = cfg_cw;
        cfg_in.cy    = cfg_cy;
        cfg_in.ch    = cfg_ch;
        cfg_in.inset = cfg_inset;
        cfg_in.bg    = cfg_bg;
        cfg_in.crs   = cfg_cross;
        cfg_in.inner = cfg_inner;

        xfer     = cfg_valid && !pend_q;
        pend_d   = pend_q;
        shadow_d = shadow_q;
        active_d = active_q;
        // xfer implies pend_q=0, so a coincident frame never promotes it
        if (frame && pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end
        if (xfer) begin
            shadow_d = cfg_in;
            pend_d   = 1'b1;
        end
    end

    always_comb begin
        s1_de_d        = de;
        s1_out_d       = ({1'b0, sx} >= FW) || ({1'b0, sy} >= FH);
        s1_band_d      = vbar || hbar;
        s1_inner_d     = vinner || hinner;
        // colours travel with the pixel so an apply mid-pipeline cannot mix configs
        s1_pal_d.bg    = active_q.bg;
        s1_pal_d.crs   = active_q.crs;
        s1_pal_d.inner = active_q.inner;
    end

    always_comb begin
        paint_de_d = s1_de_q;
        paint_d    = '0;
        if (s1_de_q && !s1_out_q) begin
            if (s1_inner_q)     paint_d = s1_pal_q.inner;
            else if (s1_band_q) paint_d = s1_pal_q.crs;
            else                paint_d = s1_pal_q.bg;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            pend_q     <= 1'b0;
            shadow_q   <= '0;
            active_q   <= CFG_SWEDEN;
            s1_de_q    <= 1'b0;
            s1_out_q   <= 1'b0;
            s1_band_q  <= 1'b0;
            s1_inner_q <= 1'b0;
            s1_pal_q   <= '0;
            paint_de_q <= 1'b0;
            paint_q    <= '0;
        end else begin
            pend_q     <= pend_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            s1_de_q    <= s1_de_d;
            s1_out_q   <= s1_out_d;
            s1_band_q  <= s1_band_d;
            s1_inner_q <= s1_inner_d;
            s1_pal_q   <= s1_pal_d;
            paint_de_q <= paint_de_d;
            paint_q    <= paint_d;
        end
    end

    assign cfg_ready = ~pend_q;
    assign paint_de  = paint_de_q;
    assign paint_r   = paint_q.r;
    assign paint_g   = paint_q.g;
    assign paint_b   = paint_q.b;

endmodule

// File: tb/tb_flag_nordic_cross.sv
// Scoreboard bench: pixel drivers push expected colour and due cycle,
// a free-running monitor pops and compares whenever paint_de is high.
module tb_flag_nordic_cross;

    import flag_pkg::*;

    logic               clk_pix = 1'b0;
    logic               rst_pix_n = 1'b0;
    logic               frame = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [CORDW-1:0]   cfg_cx = '0, cfg_cw = '0, cfg_cy = '0, cfg_ch = '0, cfg_inset = '0;
    logic [3*COLRW-1:0] cfg_bg = '0, cfg_cross = '0, cfg_inner = '0;
    logic               de = 1'b0;
    logic [CORDW-1:0]   sx = '0, sy = '0;
    logic               paint_de;
    logic [COLRW-1:0]   paint_r, paint_g, paint_b;
    logic [3*COLRW-1:0] rgb;

    assign rgb = {paint_r, paint_g, paint_b};

    flag_nordic_cross #(
        .CORDW  (CORDW),
        .COLRW  (COLRW),
        .FLAG_W (640),
        .FLAG_H (400)
    ) dut (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .frame     (frame),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_cx    (cfg_cx),
        .cfg_cw    (cfg_cw),
        .cfg_cy    (cfg_cy),
        .cfg_ch    (cfg_ch),
        .cfg_inset (cfg_inset),
        .cfg_bg    (cfg_bg),
        .cfg_cross (cfg_cross),
        .cfg_inner (cfg_inner),
        .de        (de),
        .sx        (sx),
        .sy        (sy),
        .paint_de  (paint_de),
        .paint_r   (paint_r),
        .paint_g   (paint_g),
        .paint_b   (paint_b)
    );

    always #5 clk_pix = ~clk_pix;

    int cyc = 0;
    always @(posedge clk_pix) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [11:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_pix);
            #1;
            if (mon_en) begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_paint: no paint_de at cycle %0d, seen none by %0d", sb[0].due, cyc);
                    void'(sb.pop_front());
                end
                if (paint_de) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_paint: paint_de=1 rgb %0h at cycle %0d, none expected", rgb, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("paint_cycle", cyc, e.due);
                        chk("paint_rgb", {20'h0, rgb}, {20'h0, e.rgb});
                    end
                end else begin
                    chk("idle_rgb_zero", {20'h0, rgb}, 32'h0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic cross_cfg_t mk_cfg(input int cx, input int cw, input int cy, input int ch,
                                          input int inset, input logic [11:0] bg,
                                          input logic [11:0] cr, input logic [11:0] inr);
        cross_cfg_t c;
        c.cx    = CORDW'(cx);
        c.cw    = CORDW'(cw);
        c.cy    = CORDW'(cy);
        c.ch    = CORDW'(ch);
        c.inset = CORDW'(inset);
        c.bg    = bg;
        c.crs   = cr;
        c.inner = inr;
        return c;
    endfunction

    task automatic set_px(input int x, input int y, input logic [11:0] exp);
        de = 1'b1;
        sx = CORDW'(x);
        sy = CORDW'(y);
        sb.push_back('{due: cyc + 2, rgb: exp});
    endtask

    task automatic px(input int x, input int y, input logic [11:0] exp);
        @(posedge clk_pix);
        #1;
        frame = 1'b0;
        set_px(x, y, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_pix);
            #1;
            de    = 1'b0;
            frame = 1'b0;
        end
    endtask

    task automatic pulse_frame();
        @(posedge clk_pix);
        #1;
        de    = 1'b0;
        frame = 1'b1;
        @(posedge clk_pix);
        #1;
        frame = 1'b0;
    endtask

    task automatic drive_cfg(input cross_cfg_t c);
        cfg_cx    = c.cx;
        cfg_cw    = c.cw;
        cfg_cy    = c.cy;
        cfg_ch    = c.ch;
        cfg_inset = c.inset;
        cfg_bg    = c.bg;
        cfg_cross = c.crs;
        cfg_inner = c.inner;
    endtask

    task automatic send_cfg(input cross_cfg_t c, input bit with_frame);
        int n;
        @(posedge clk_pix);
        #1;
        de    = 1'b0;
        frame = 1'b0;
        drive_cfg(c);
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 50) begin
            @(posedge clk_pix);
            #1;
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL cfg_ready_timeout: ready stayed 0 for %0d cycles, required 1", n);
        end
        if (with_frame) frame = 1'b1;
        @(posedge clk_pix);
        #1;
        cfg_valid = 1'b0;
        frame     = 1'b0;
        chk("ready_drop_after_xfer", {31'h0, cfg_ready}, 32'h0);
    endtask

    initial begin : stim
        repeat (3) @(posedge clk_pix);
        #1;
        chk("rst_paint_de", {31'h0, paint_de}, 32'h0);
        chk("rst_rgb", {20'h0, rgb}, 32'h0);
        chk("rst_cfg_ready", {31'h0, cfg_ready}, 32'h1);
        rst_pix_n = 1'b1;
        mon_en    = 1'b1;

        // Sweden defaults
        pulse_frame();
        px(100, 100, 12'h06A);
        px(200, 100, 12'hFC0);
        px(199, 100, 12'h06A);
        px(279, 100, 12'hFC0);
        px(280, 100, 12'h06A);
        px(100, 239, 12'hFC0);
        px(100, 240, 12'h06A);
        px(10, 400, 12'h000);
        px(640, 100, 12'h000);
        idle(1);
        px(250, 170, 12'hFC0);
        idle(4);

        // Norway: staged, invisible until frame
        send_cfg(mk_cfg(180, 120, 140, 120, 20, 12'hC12, 12'hFFF, 12'h025), 1'b0);
        px(250, 50, 12'hFC0);
        @(posedge clk_pix);
        #1;
        de = 1'b0;
        drive_cfg(mk_cfg(1, 1, 1, 1, 0, 12'h111, 12'h222, 12'h333));
        cfg_valid = 1'b1;
        repeat (3) begin
            @(posedge clk_pix);
            #1;
            chk("ready_held_off", {31'h0, cfg_ready}, 32'h0);
        end
        cfg_valid = 1'b0;
        @(posedge clk_pix);
        #1;
        chk("ready_before_frame", {31'h0, cfg_ready}, 32'h0);
        frame = 1'b1;
        set_px(250, 50, 12'hFC0);
        @(posedge clk_pix);
        #1;
        chk("ready_after_frame", {31'h0, cfg_ready}, 32'h1);
        frame = 1'b0;
        set_px(250, 50, 12'h025);
        px(185, 50, 12'hFFF);
        px(100, 50, 12'hC12);
        px(299, 50, 12'hFFF);
        px(300, 50, 12'hC12);
        px(185, 150, 12'hFFF);
        px(185, 200, 12'h025);
        px(100, 200, 12'h025);
        px(100, 259, 12'hFFF);
        idle(4);

        // transfer coincident with frame lands one frame later
        send_cfg(mk_cfg(600, 100, 0, 0, 0, 12'h111, 12'h8F8, 12'h000), 1'b1);
        px(250, 50, 12'h025);
        idle(1);
        chk("ready_pending_coincident", {31'h0, cfg_ready}, 32'h0);
        pulse_frame();
        px(600, 10, 12'h8F8);
        px(639, 10, 12'h8F8);
        px(599, 10, 12'h111);
        px(640, 10, 12'h000);
        px(0, 10, 12'h111);
        px(59, 10, 12'h111);
        px(300, 0, 12'h111);
        idle(4);

        // zero-width vertical bar
        send_cfg(mk_cfg(100, 0, 100, 50, 0, 12'h123, 12'h456, 12'h789), 1'b0);
        pulse_frame();
        px(100, 10, 12'h123);
        px(99, 10, 12'h123);
        px(100, 120, 12'h456);
        px(100, 150, 12'h123);
        idle(4);

        // inset 40: no inner vbar at cw=80, two-row inner hbar at ch=82
        send_cfg(mk_cfg(100, 80, 300, 82, 40, 12'h0F0, 12'hF00, 12'h00F), 1'b0);
        pulse_frame();
        px(140, 10, 12'hF00);
        px(100, 10, 12'hF00);
        px(179, 10, 12'hF00);
        px(180, 10, 12'h0F0);
        px(10, 339, 12'hF00);
        px(10, 340, 12'h00F);
        px(10, 341, 12'h00F);
        px(10, 342, 12'hF00);
        px(140, 340, 12'h00F);
        idle(4);

        // reset mid-line with a pending config
        send_cfg(mk_cfg(0, 640, 0, 400, 0, 12'hABC, 12'hABC, 12'hABC), 1'b0);
        px(10, 10, 12'h0F0);
        px(140, 10, 12'hF00);
        @(posedge clk_pix);
        #3;
        rst_pix_n = 1'b0;
        de        = 1'b0;
        sb.delete();
        repeat (3) begin
            @(posedge clk_pix);
            #1;
            chk("mid_rst_paint_de", {31'h0, paint_de}, 32'h0);
            chk("mid_rst_rgb", {20'h0, rgb}, 32'h0);
        end
        rst_pix_n = 1'b1;
        chk("post_rst_cfg_ready", {31'h0, cfg_ready}, 32'h1);
        pulse_frame();
        px(100, 100, 12'h06A);
        px(200, 100, 12'hFC0);
        px(100, 239, 12'hFC0);
        idle(2);
        pulse_frame();
        px(100, 100, 12'h06A);
        px(10, 10, 12'h06A);
        idle(5);

        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
